iq_dispatch: RTL and testbench

// - In-order dispatch stage feeding the 3-entry instruction queue controller across its two dispatch ports.
// - Buffers instructions arriving from fetch over a valid/ready handshake.
// - Tracks free queue entries with a credit counter and drives the per-port load requests.
// - Never requests more loads than the queue has free entries.

---
 rtl/iq_dispatch_if.sv | 11 +
 rtl/iq_dispatch.sv | 106 ++++++++++
 tb/tb_iq_dispatch.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/iq_dispatch_if.sv
// Fetch-to-dispatch valid/ready handshake carrying one instruction payload per transfer.
interface iq_dispatch_if #(
  parameter int IW = 16
) ();
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/iq_dispatch.sv
// In-order dispatch: buffers fetched instructions and loads up to two per cycle into the
// instruction queue, limited by a free-entry credit counter. Optional macro IQD_BYPASS_EN.
module iq_dispatch #(
  parameter int QDEPTH    = 3,
  parameter int BUF_DEPTH = 4,
  parameter int IW        = 16
) (
  input  logic                           clock,
  input  logic                           reset_n,
  iq_dispatch_if.slave                   fetch,
  input  logic                           hold,
  input  logic                           flush_all,
  input  logic [1:0]                     freed,
  output logic [1:0]                     iqLoads,
  output logic [IW-1:0]                  disp_data0,
  output logic [IW-1:0]                  disp_data1,
  output logic [$clog2(QDEPTH+1)-1:0]    credits,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count,
  output logic                           credit_err
);
  localparam int CW  = $clog2(QDEPTH + 1);
  localparam int BCW = $clog2(BUF_DEPTH + 1);
  localparam int PW  = $clog2(BUF_DEPTH);
  localparam int SW  = CW + 2;

  logic [IW-1:0]  mem [BUF_DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr1;
  logic [BCW-1:0] cnt;
  logic [CW-1:0]  cred;
  logic           err;
  logic [1:0]     n;
  logic [1:0]     n_cred;
  logic           byp;
  logic           push;
  logic [IW-1:0]  head;
  logic [SW-1:0]  sum;

  // Dispatch count from registered state only; flush and hold both suppress loads.
  always_comb begin
    n = 2'd0;
    if (!hold && !flush_all) begin
      if (int'(cnt) >= 2 && int'(cred) >= 2)
        n = 2'd2;
      else if (cnt != '0 && cred != '0)
        n = 2'd1;
    end
  end

`ifdef IQD_BYPASS_EN
  assign byp  = (cnt == '0) && (cred != '0) && !hold && !flush_all && fetch.in_valid;
  assign head = byp ? fetch.in_data : mem[rd_ptr];
`else
  assign byp  = 1'b0;
  assign head = mem[rd_ptr];
`endif

  assign fetch.in_ready = (cnt < BCW'(BUF_DEPTH));
  assign push    = fetch.in_valid && fetch.in_ready && !flush_all && !byp;
  assign n_cred  = n | {1'b0, byp};
  assign rd_ptr1 = rd_ptr + PW'(1);

  assign iqLoads    = {n[1], (|n) | byp};
  assign disp_data0 = iqLoads[0] ? head : '0;
  assign disp_data1 = iqLoads[1] ? mem[rd_ptr1] : '0;

  assign sum = SW'(cred) - SW'(n_cred) + SW'(freed);

  assign credits    = cred;
  assign buf_count  = cnt;
  assign credit_err = err;

  // Storage is data only and needs no reset.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= fetch.in_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      cred   <= CW'(QDEPTH);
      err    <= 1'b0;
    end else begin
      if (flush_all) begin
        cnt    <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        cnt    <= cnt + BCW'(push) - BCW'(n);
        rd_ptr <= rd_ptr + PW'(n);
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
      end
      // Returning more entries than exist means the queue and dispatch disagree.
      if (sum > SW'(QDEPTH)) begin
        cred <= CW'(QDEPTH);
        err  <= 1'b1;
      end else begin
        cred <= sum[CW-1:0];
      end
    end
  end
endmodule

// File: tb/tb_iq_dispatch.sv
// Directed table-driven bench for iq_dispatch plus hand-written reset and bypass sequences.
module tb_iq_dispatch;
  logic        clock;
  logic        reset_n;
  logic        hold;
  logic        flush_all;
  logic [1:0]  freed;
  logic [1:0]  iqLoads;
  logic [15:0] disp_data0;
  logic [15:0] disp_data1;
  logic [1:0]  credits;
  logic [2:0]  buf_count;
  logic        credit_err;

  int vectors;
  int miscompares;

  iq_dispatch_if #(.IW(16)) fetch_if ();

  iq_dispatch #(.QDEPTH(3), .BUF_DEPTH(4), .IW(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .fetch      (fetch_if),
    .hold       (hold),
    .flush_all  (flush_all),
    .freed      (freed),
    .iqLoads    (iqLoads),
    .disp_data0 (disp_data0),
    .disp_data1 (disp_data1),
    .credits    (credits),
    .buf_count  (buf_count),
    .credit_err (credit_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        h;
    logic        f;
    logic [1:0]  fr;
    logic [1:0]  ld;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  cr;
    logic [2:0]  cnt;
    logic        rdy;
    logic        err;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(logic v, logic [15:0] d, logic h, logic f, logic [1:0] fr,
                              logic [1:0] ld, logic [15:0] d0, logic [15:0] d1,
                              logic [1:0] cr, logic [2:0] cnt, logic rdy, logic err);
    vec_t r;
    r.v = v; r.d = d; r.h = h; r.f = f; r.fr = fr;
    r.ld = ld; r.d0 = d0; r.d1 = d1; r.cr = cr; r.cnt = cnt; r.rdy = rdy; r.err = err;
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      miscompares++;
    end
  endtask

  task automatic check_outs(int idx, logic [1:0] ld, logic [15:0] d0, logic [15:0] d1,
                            logic [1:0] cr, logic [2:0] cnt, logic rdy, logic err);
    vectors++;
    chk("iqLoads",    idx, 32'(iqLoads),         32'(ld));
    chk("disp_data0", idx, 32'(disp_data0),      32'(d0));
    chk("disp_data1", idx, 32'(disp_data1),      32'(d1));
    chk("credits",    idx, 32'(credits),         32'(cr));
    chk("buf_count",  idx, 32'(buf_count),       32'(cnt));
    chk("in_ready",   idx, 32'(fetch_if.in_ready), 32'(rdy));
    chk("credit_err", idx, 32'(credit_err),      32'(err));
  endtask

  task automatic drive(logic v, logic [15:0] d, logic h, logic f, logic [1:0] fr);
    @(negedge clock);
    fetch_if.in_valid = v;
    fetch_if.in_data  = d;
    hold      = h;
    flush_all = f;
    freed     = fr;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    hold        = 1'b0;
    flush_all   = 1'b0;
    freed       = 2'd0;
    fetch_if.in_valid = 1'b0;
    fetch_if.in_data  = 16'h0;

    //              v  data      h  f  fr   ld     d0        d1        cr   cnt  rdy err
    tbl[0]  = mk(0, 16'h0000, 0, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd3, 3'd0, 1, 0);
    tbl[1]  = mk(1, 16'hA001, 0, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd3, 3'd0, 1, 0);
    tbl[2]  = mk(1, 16'hB002, 0, 0, 2'd0, 2'b01, 16'hA001, 16'h0000, 2'd3, 3'd1, 1, 0);
    tbl[3]  = mk(1, 16'hC003, 0, 0, 2'd0, 2'b01, 16'hB002, 16'h0000, 2'd2, 3'd1, 1, 0);
    tbl[4]  = mk(1, 16'hD004, 0, 0, 2'd0, 2'b01, 16'hC003, 16'h0000, 2'd1, 3'd1, 1, 0);
    tbl[5]  = mk(0, 16'h0000, 0, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd0, 3'd1, 1, 0);
    tbl[6]  = mk(0, 16'h0000, 0, 0, 2'd2, 2'b00, 16'h0000, 16'h0000, 2'd0, 3'd1, 1, 0);
    tbl[7]  = mk(0, 16'h0000, 0, 0, 2'd0, 2'b01, 16'hD004, 16'h0000, 2'd2, 3'd1, 1, 0);
    tbl[8]  = mk(1, 16'hE005, 0, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd1, 3'd0, 1, 0);
    tbl[9]  = mk(1, 16'h1006, 0, 0, 2'd0, 2'b01, 16'hE005, 16'h0000, 2'd1, 3'd1, 1, 0);
    tbl[10] = mk(1, 16'h2007, 0, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd0, 3'd1, 1, 0);
    tbl[11] = mk(1, 16'h3008, 0, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd0, 3'd2, 1, 0);
    tbl[12] = mk(1, 16'h4009, 0, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd0, 3'd3, 1, 0);
    tbl[13] = mk(1, 16'h500A, 0, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd0, 3'd4, 0, 0);
    tbl[14] = mk(1, 16'h500A, 0, 0, 2'd2, 2'b00, 16'h0000, 16'h0000, 2'd0, 3'd4, 0, 0);
    tbl[15] = mk(1, 16'h500A, 0, 0, 2'd0, 2'b11, 16'h1006, 16'h2007, 2'd2, 3'd4, 0, 0);
    tbl[16] = mk(1, 16'h500A, 0, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd0, 3'd2, 1, 0);
    tbl[17] = mk(0, 16'h0000, 1, 0, 2'd1, 2'b00, 16'h0000, 16'h0000, 2'd0, 3'd3, 1, 0);
    tbl[18] = mk(0, 16'h0000, 1, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd1, 3'd3, 1, 0);
    tbl[19] = mk(1, 16'h600B, 0, 1, 2'd1, 2'b00, 16'h0000, 16'h0000, 2'd1, 3'd3, 1, 0);
    tbl[20] = mk(0, 16'h0000, 0, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd2, 3'd0, 1, 0);
    tbl[21] = mk(0, 16'h0000, 0, 0, 2'd1, 2'b00, 16'h0000, 16'h0000, 2'd2, 3'd0, 1, 0);
    tbl[22] = mk(0, 16'h0000, 0, 0, 2'd1, 2'b00, 16'h0000, 16'h0000, 2'd3, 3'd0, 1, 0);
    tbl[23] = mk(0, 16'h0000, 0, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd3, 3'd0, 1, 1);
    tbl[24] = mk(1, 16'h700C, 0, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd3, 3'd0, 1, 1);
    tbl[25] = mk(0, 16'h0000, 0, 0, 2'd0, 2'b01, 16'h700C, 16'h0000, 2'd3, 3'd1, 1, 1);
    tbl[26] = mk(0, 16'h0000, 0, 0, 2'd0, 2'b00, 16'h0000, 16'h0000, 2'd2, 3'd0, 1, 1);

    do_reset();

`ifdef IQD_BYPASS_EN
    drive(0, 16'h0000, 0, 0, 2'd0);
    check_outs(100, 2'b00, 16'h0000, 16'h0000, 2'd3, 3'd0, 1, 0);
    drive(1, 16'hBEEF, 0, 0, 2'd0);
    check_outs(101, 2'b01, 16'hBEEF, 16'h0000, 2'd3, 3'd0, 1, 0);
    drive(0, 16'h0000, 0, 0, 2'd0);
    check_outs(102, 2'b00, 16'h0000, 16'h0000, 2'd2, 3'd0, 1, 0);
`else
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].h, tbl[i].f, tbl[i].fr);
      check_outs(i, tbl[i].ld, tbl[i].d0, tbl[i].d1, tbl[i].cr, tbl[i].cnt, tbl[i].rdy,
                 tbl[i].err);
    end
`endif

    // Reset in the middle of operation: buffered entries are discarded asynchronously.
    drive(1, 16'h8001, 1, 0, 2'd0);
    drive(1, 16'h8002, 1, 0, 2'd0);
    drive(0, 16'h0000, 1, 0, 2'd0);
    chk("mid_fill_count", 200, 32'(buf_count), 32'd2);
    vectors++;
    hold = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check_outs(201, 2'b00, 16'h0000, 16'h0000, 2'd3, 3'd0, 1, 0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(0, 16'h0000, 0, 0, 2'd0);
    check_outs(202, 2'b00, 16'h0000, 16'h0000, 2'd3, 3'd0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
